run_ctrl: RTL and testbench

Parametrised run controller for the single-cycle RISC-V processor. It sequences the core's active-low reset for a configurable length, runs the core, and counts cycles. Completion is detected from a tohost store, a PC self-loop halt, or a watchdog timeout, and the result is latched as a sticky status. It sits between top-level control (a bench or board logic) and the `Processor` reset input, so the hard-coded reset/run timing of the processor test harness becomes synthesizable, reusable logic.

---
 rtl/run_ctrl_pkg.sv | 21 ++
 rtl/stall_detect.sv | 42 ++++
 rtl/run_ctrl.sv | 125 ++++++++++++
 tb/tb_run_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM states and the sticky result codes.
package run_ctrl_pkg;

   localparam int RUN_STATUS_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } run_state_t;

   typedef enum logic [RUN_STATUS_W-1:0] {
      RS_NONE    = 3'd0,
      RS_PASS    = 3'd1,
      RS_FAIL    = 3'd2,
      RS_TIMEOUT = 3'd3,
      RS_HALT    = 3'd4
   } run_status_t;

endpackage

// File: rtl/stall_detect.sv
// PC self-loop detector: halt is asserted combinationally on the STALL_CYCLES-th consecutive equal PC.
// Latency: same cycle as the final matching PC; no backpressure.
module stall_detect
   import run_ctrl_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int STALL_CYCLES = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic [XLEN-1:0] pc,
   output logic            halt
);

   localparam int CW = $clog2(STALL_CYCLES + 1);

   logic [XLEN-1:0] prev_pc;
   logic            prev_vld;
   logic [CW-1:0]   match_cnt;
   logic            match;

   // No previous PC exists on the first cycle after a clear, so no match is possible then.
   assign match = prev_vld && (pc == prev_pc);
   assign halt  = match && (match_cnt == CW'(STALL_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         prev_pc   <= '0;
         prev_vld  <= 1'b0;
         match_cnt <= '0;
      end else begin
         prev_pc  <= pc;
         prev_vld <= 1'b1;
         if (!match)
            match_cnt <= '0;
         else if (match_cnt != CW'(STALL_CYCLES))
            match_cnt <= match_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset, runs the core, and latches a sticky result on tohost/halt/timeout.
// Latency: exit detected in RUN cycle k is visible (done/status) the next cycle; no backpressure.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int              CNT_W        = 32,
   parameter int              RST_CYCLES   = 4,
   parameter int              TIMEOUT      = 1000,
   parameter int              STALL_CYCLES = 8,
   parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_0FFC
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [XLEN-1:0]         pc,
   input  logic                    dmem_we,
   input  logic [XLEN-1:0]         dmem_addr,
   input  logic [XLEN-1:0]         dmem_wdata,
   output logic                    core_rst,
   output logic                    running,
   output logic                    done,
   output logic [RUN_STATUS_W-1:0] status,
   output logic [XLEN-1:0]         result,
   output logic [CNT_W-1:0]        cycle_count
);

   localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   run_state_t      state, state_nxt;
   run_status_t     status_q, exit_status;
   logic            exit_hit;
   logic [RW-1:0]   rst_cnt;
   logic [XLEN-1:0] result_q;
   logic [CNT_W-1:0] cycle_q;
   logic            tohost_hit, halt, timeout_hit;

   stall_detect #(
      .XLEN         (XLEN),
      .STALL_CYCLES (STALL_CYCLES)
   ) u_stall (
      .clk   (clk),
      .rst   (rst),
      .clear (state != ST_RUN),
      .pc    (pc),
      .halt  (halt)
   );

   assign tohost_hit  = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != '0);
   assign timeout_hit = (cycle_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Exit priority: tohost result, then PC halt, then watchdog.
   always_comb begin
      state_nxt   = state;
      exit_hit    = 1'b0;
      exit_status = RS_NONE;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_RESET;
         ST_RESET: if (rst_cnt == '0) state_nxt = ST_RUN;
         ST_RUN: begin
            if (tohost_hit) begin
               exit_hit    = 1'b1;
               exit_status = (dmem_wdata == XLEN'(1)) ? RS_PASS : RS_FAIL;
            end else if (halt) begin
               exit_hit    = 1'b1;
               exit_status = RS_HALT;
            end else if (timeout_hit) begin
               exit_hit    = 1'b1;
               exit_status = RS_TIMEOUT;
            end
            if (exit_hit) state_nxt = ST_DONE;
         end
         ST_DONE:  if (start) state_nxt = ST_RESET;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode the state register only, so nothing combinational reaches them from inputs.
   always_comb begin
      core_rst = (state == ST_RUN);
      running  = (state == ST_RUN);
      done     = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rst_cnt  <= '0;
         status_q <= RS_NONE;
         result_q <= '0;
         cycle_q  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  rst_cnt  <= RW'(RST_CYCLES - 1);
                  status_q <= RS_NONE;
                  result_q <= '0;
                  cycle_q  <= '0;
               end
            end
            ST_RESET: begin
               if (rst_cnt != '0) rst_cnt <= rst_cnt - RW'(1);
            end
            ST_RUN: begin
               if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
               if (exit_hit)      status_q <= exit_status;
               if (tohost_hit)    result_q <= dmem_wdata;
            end
            default: ;
         endcase
      end
   end

   assign status      = status_q;
   assign result      = result_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: a table of run scenarios plus hand-written reset/start sequences.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   localparam int RST_CYCLES   = 4;
   localparam int TIMEOUT      = 1000;
   localparam int STALL_CYCLES = 8;
   localparam logic [31:0] TOHOST = 32'h0000_0FFC;

   logic        clk = 1'b0;
   logic        rst, start, dmem_we;
   logic [31:0] pc, dmem_addr, dmem_wdata;
   logic        core_rst, running, done;
   logic [2:0]  status;
   logic [31:0] result, cycle_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   run_ctrl #(
      .XLEN         (32),
      .CNT_W        (32),
      .RST_CYCLES   (RST_CYCLES),
      .TIMEOUT      (TIMEOUT),
      .STALL_CYCLES (STALL_CYCLES),
      .TOHOST_ADDR  (TOHOST)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .pc          (pc),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .core_rst    (core_rst),
      .running     (running),
      .done        (done),
      .status      (status),
      .result      (result),
      .cycle_count (cycle_count)
   );

   typedef struct {
      int          st_cyc;     // RUN cycle carrying a store (0 = none)
      logic [31:0] st_addr;
      logic [31:0] st_data;
      int          hold;       // RUN cycle from which pc is held at 0x40 (0 = never)
      int          glitch;     // RUN cycle where the held pc briefly moves to 0x44
      logic [2:0]  exp_status;
      logic [31:0] exp_result;
      int          exp_count;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int k;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d start flags", id), {61'd0, done, core_rst, running}, 64'd0);
      chk($sformatf("v%0d start status", id), 64'(status), 64'(RS_NONE));
      chk($sformatf("v%0d start result", id), 64'(result), 64'd0);
      chk($sformatf("v%0d start count", id), 64'(cycle_count), 64'd0);
      for (int i = 1; i < RST_CYCLES; i++) begin
         tick();
         chk($sformatf("v%0d core_rst held %0d", id, i), 64'(core_rst), 64'd0);
      end
      tick();
      k = 1;
      while (!done && k <= TIMEOUT + 10) begin
         if (v.hold != 0 && k == v.glitch)       pc = 32'h44;
         else if (v.hold != 0 && k >= v.hold)    pc = 32'h40;
         else                                    pc = 32'h100 + 32'(4 * k);
         if (k == v.st_cyc) begin
            dmem_we = 1'b1; dmem_addr = v.st_addr; dmem_wdata = v.st_data;
         end else begin
            dmem_we = 1'b0; dmem_addr = TOHOST; dmem_wdata = 32'd1;
         end
         chk($sformatf("v%0d run cycle %0d", id, k), {29'd0, running, core_rst, done, cycle_count},
             {29'd0, 3'b110, 32'(k - 1)});
         tick();
         k++;
      end
      dmem_we = 1'b0;
      chk($sformatf("v%0d done flags", id), {61'd0, done, core_rst, running}, 64'b100);
      chk($sformatf("v%0d status", id), 64'(status), 64'(v.exp_status));
      chk($sformatf("v%0d result", id), 64'(result), 64'(v.exp_result));
      chk($sformatf("v%0d count", id), 64'(cycle_count), 64'(v.exp_count));
      tick();
      chk($sformatf("v%0d sticky", id), {done, status, cycle_count}, {1'b1, v.exp_status, 32'(v.exp_count)});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{20,   TOHOST,       32'd1, 0,   0,  RS_PASS,    32'd1, 20};
      vecs[1] = '{20,   TOHOST,       32'd7, 0,   0,  RS_FAIL,    32'd7, 20};
      vecs[2] = '{5,    TOHOST,       32'd0, 10,  0,  RS_HALT,    32'd0, 18};
      vecs[3] = '{5,    32'h0FF8,     32'd1, 10,  0,  RS_HALT,    32'd0, 18};
      vecs[4] = '{0,    TOHOST,       32'd0, 10,  17, RS_HALT,    32'd0, 26};
      vecs[5] = '{0,    TOHOST,       32'd0, 0,   0,  RS_TIMEOUT, 32'd0, 1000};
      vecs[6] = '{1000, TOHOST,       32'd1, 0,   0,  RS_PASS,    32'd1, 1000};
      vecs[7] = '{0,    TOHOST,       32'd0, 992, 0,  RS_HALT,    32'd0, 1000};
      vecs[8] = '{1000, TOHOST,       32'd5, 992, 0,  RS_FAIL,    32'd5, 1000};
      vecs[9] = '{1,    TOHOST,       32'd1, 0,   0,  RS_PASS,    32'd1, 1};

      rst = 1'b0; start = 1'b0; pc = '0;
      dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
      tick(); tick();
      chk("reset flags", {61'd0, core_rst, running, done}, 64'd0);
      chk("reset status/result/count", {status, result, cycle_count}, 67'd0);

      // start coincident with reset must be dropped
      start = 1'b1;
      tick();
      rst = 1'b1; start = 1'b0;
      for (int i = 0; i < RST_CYCLES + 2; i++) tick();
      chk("start under reset ignored", {61'd0, core_rst, running, done}, 64'd0);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // mid-run reset, with start held high during RUN (ignored)
      start = 1'b1;
      tick();
      for (int i = 0; i < RST_CYCLES; i++) tick();
      for (int k = 1; k <= 5; k++) begin
         pc = 32'h200 + 32'(4 * k);
         tick();
      end
      chk("start ignored in RUN", {running, cycle_count}, {1'b1, 32'd5});
      rst = 1'b0; start = 1'b0;
      tick();
      chk("mid-run reset flags", {61'd0, core_rst, running, done}, 64'd0);
      chk("mid-run reset values", {status, result, cycle_count}, 67'd0);
      rst = 1'b1;
      tick(); tick();
      chk("idle after reset", {61'd0, core_rst, running, done}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
